// File: rtl/alu_pkg.sv
// Shared opcode, type, state and flag definitions for the sequential ALU.
package alu_pkg;

  localparam int unsigned OP_W   = 4;
  localparam int unsigned TYPE_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0010;
  localparam logic [OP_W-1:0] OP_DIV = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND = 4'b0100;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0101;
  localparam logic [OP_W-1:0] OP_XOR = 4'b0110;
  localparam logic [OP_W-1:0] OP_NEG = 4'b0111;
  localparam logic [OP_W-1:0] OP_MOV = 4'b1000;

  localparam logic [TYPE_W-1:0] TYPE_DP = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic carry;
    logic overflow;
    logic div_by_zero;
  } flags_t;

  // MUL and DIV are the only ops that go through the iterative datapath
  function automatic logic is_iterative(input logic [TYPE_W-1:0] tc,
                                        input logic [OP_W-1:0]   op);
    return (tc == TYPE_DP) && ((op == OP_MUL) || (op == OP_DIV));
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned magnitude datapath: shift-add multiply and restoring
// shift-subtract divide, one step per cycle, WIDTH steps per operation.
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             div_mode,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH-1:0] mag_result_c,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] shf_q;
  logic [WIDTH-1:0] opnd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             div_q;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] addend;

  // acc holds product (MUL) or partial remainder (DIV); shf holds the
  // multiplier (MUL) or the dividend being replaced by quotient bits (DIV)
  always_comb begin
    rem_shift = {acc_q, shf_q[WIDTH-1]};
    fits      = rem_shift >= {1'b0, opnd_q};
    trial     = rem_shift[WIDTH-1:0] - opnd_q;
    addend    = shf_q[0] ? opnd_q : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      shf_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      div_q  <= 1'b0;
    end else if (load) begin
      acc_q  <= '0;
      shf_q  <= div_mode ? mag_a : mag_b;
      opnd_q <= div_mode ? mag_b : mag_a;
      cnt_q  <= '0;
      div_q  <= div_mode;
    end else if (step) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (div_q) begin
        acc_q <= fits ? trial : rem_shift[WIDTH-1:0];
        shf_q <= {shf_q[WIDTH-2:0], fits};
      end else begin
        acc_q  <= acc_q + addend;
        shf_q  <= shf_q >> 1;
        opnd_q <= opnd_q << 1;
      end
    end
  end

  assign mag_result_c = div_q ? shf_q : acc_q;
  assign last_c       = cnt_q == CNT_W'(WIDTH - 1);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle arithmetic/logic plus iterative MUL/DIV
// behind a start/busy/done handshake, with registered N/Z/C/V/div-by-zero flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TYPE_W-1:0] type_code,
  input  logic [OP_W-1:0]   op_code,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              negative,
  output logic              zero,
  output logic              carry,
  output logic              overflow,
  output logic              div_by_zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic             load, step, wr;
  logic             last_c;
  logic [WIDTH-1:0] mag_a, mag_b, mag_res_c;
  logic             neg_q, div_q;

  logic             dp, is_div, b_zero, iter;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] neg_a, neg_b;

  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v, sc_dbz;
  logic [WIDTH-1:0] fin_res;
  logic             fin_v;

  logic [WIDTH-1:0] res_d;
  flags_t           flg_d;

  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;
  logic             busy_q, done_q;

  assign dp     = type_code == TYPE_DP;
  assign is_div = dp && (op_code == OP_DIV);
  assign b_zero = b == '0;
  // divide by zero short-circuits to a single-cycle completion
  assign iter   = is_iterative(type_code, op_code) && !(is_div && b_zero);

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign neg_a = '0 - a;
  assign neg_b = '0 - b;
  assign mag_a = a[WIDTH-1] ? neg_a : a;
  assign mag_b = b[WIDTH-1] ? neg_b : b;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .step         (step),
    .div_mode     (is_div),
    .mag_a        (mag_a),
    .mag_b        (mag_b),
    .mag_result_c (mag_res_c),
    .last_c       (last_c)
  );

  // Single-cycle result and C/V/div-by-zero
  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dbz = 1'b0;
    if (!dp) begin
      sc_res = b;
    end else begin
      case (op_code)
        OP_ADD: begin
          sc_res = sum[WIDTH-1:0];
          sc_c   = sum[WIDTH];
          sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        OP_SUB: begin
          sc_res = diff[WIDTH-1:0];
          sc_c   = ~diff[WIDTH];
          sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        OP_DIV: begin
          sc_res = '1;
          sc_dbz = 1'b1;
        end
        OP_AND: sc_res = a & b;
        OP_OR:  sc_res = a | b;
        OP_XOR: sc_res = a ^ b;
        OP_NEG: begin
          sc_res = neg_a;
          sc_v   = a == MIN_VAL;
        end
        OP_MOV: sc_res = b;
        default: sc_res = '0;
      endcase
    end
  end

  // Sign correction of the magnitude result; only MIN/-1 yields a positive
  // quotient with the top bit set
  always_comb begin
    fin_res = neg_q ? ('0 - mag_res_c) : mag_res_c;
    fin_v   = div_q && !neg_q && mag_res_c[WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    wr      = 1'b0;
    res_d   = sc_res;
    flg_d   = '0;
    flg_d.carry       = sc_c;
    flg_d.overflow    = sc_v;
    flg_d.div_by_zero = sc_dbz;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (iter) begin
            load    = 1'b1;
            state_d = ST_RUN;
          end else begin
            wr = 1'b1;
          end
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_c) state_d = ST_FIN;
      end
      ST_FIN: begin
        wr                = 1'b1;
        state_d           = ST_IDLE;
        res_d             = fin_res;
        flg_d.carry       = 1'b0;
        flg_d.overflow    = fin_v;
        flg_d.div_by_zero = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    flg_d.negative = res_d[WIDTH-1];
    flg_d.zero     = res_d == '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      done_q <= wr;
      busy_q <= state_d != ST_IDLE;
      if (wr) begin
        result_q <= res_d;
        flags_q  <= flg_d;
      end
      if (load) begin
        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
        div_q <= is_div;
      end
    end
  end

  assign result      = result_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign negative    = flags_q.negative;
  assign zero        = flags_q.zero;
  assign carry       = flags_q.carry;
  assign overflow    = flags_q.overflow;
  assign div_by_zero = flags_q.div_by_zero;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: vector table with a result scoreboard on
// the 32-bit instance, plus hand sequences for reset abort and an 8-bit instance.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start = 1'b0;
  logic [1:0]  tc = 2'b00;
  logic [3:0]  op = 4'b0000;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, negative, zero, carry, overflow, div_by_zero;
  logic [31:0] result;

  logic        s8_start = 1'b0;
  logic [1:0]  s8_tc = 2'b00;
  logic [3:0]  s8_op = 4'b0000;
  logic [7:0]  s8_a = '0, s8_b = '0;
  logic        s8_busy, s8_done, s8_n, s8_z, s8_c, s8_v, s8_dbz;
  logic [7:0]  s8_result;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [1:0]  tc;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;   // {N,Z,C,V,DBZ}
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  flg;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .type_code(tc), .op_code(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .negative(negative), .zero(zero), .carry(carry), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .type_code(s8_tc), .op_code(s8_op),
    .a(s8_a), .b(s8_b), .busy(s8_busy), .done(s8_done), .result(s8_result),
    .negative(s8_n), .zero(s8_z), .carry(s8_c), .overflow(s8_v),
    .div_by_zero(s8_dbz)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [1:0] t, input logic [3:0] o,
                              input logic [31:0] va, input logic [31:0] vb,
                              input logic [31:0] r, input logic [4:0] f, input int l);
    vec_t v;
    v.name = nm; v.tc = t; v.op = o; v.a = va; v.b = vb;
    v.res = r; v.flg = f; v.lat = l;
    return v;
  endfunction

  // Scoreboard: every done on the 32-bit instance consumes one expectation
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({"res_", e.name}, 64'(result), 64'(e.res));
        check({"flags_", e.name}, 64'({negative, zero, carry, overflow, div_by_zero}), 64'(e.flg));
      end
    end
  end

  // Drive one op; optionally poke new start/operands while the op iterates
  task automatic run_vec(input vec_t v, input bit poke);
    exp_t e;
    int   n;
    bit   got;
    e.name = v.name; e.res = v.res; e.flg = v.flg;
    exp_q.push_back(e);
    tc = v.tc; op = v.op; a = v.a; b = v.b; start = 1'b1;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        start = 1'b0;
        if (v.lat > 1) check({"busy_", v.name}, 64'(busy), 64'(1));
      end
      if (poke) begin
        if (n == 3) begin start = 1'b1; tc = 2'b00; op = OP_ADD; a = 32'd1; b = 32'd1; end
        if (n == 7) start = 1'b0;
      end
      if (done) got = 1;
    end
    check({"lat_", v.name}, 64'(n), 64'(v.lat));
    check({"busy_at_done_", v.name}, 64'(busy), 64'(0));
  endtask

  task automatic run8(input string nm, input logic [3:0] o, input logic [7:0] va,
                      input logic [7:0] vb, input logic [7:0] r, input logic [4:0] f);
    int n;
    s8_tc = 2'b00; s8_op = o; s8_a = va; s8_b = vb; s8_start = 1'b1;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) s8_start = 1'b0;
      if (s8_done) break;
    end
    check({"lat8_", nm}, 64'(n), 64'(10));
    check({"res8_", nm}, 64'(s8_result), 64'(r));
    check({"flags8_", nm}, 64'({s8_n, s8_z, s8_c, s8_v, s8_dbz}), 64'(f));
  endtask

  initial begin
    int  n;
    bit  saw;
    logic [31:0] held;

    vecs.push_back(mk("add_ovf",   2'b00, OP_ADD, 32'h7FFFFFFF, 32'h1,        32'h80000000, 5'b10010, 1));
    vecs.push_back(mk("sub_eq",    2'b00, OP_SUB, 32'd5,        32'd5,        32'h0,        5'b01100, 1));
    vecs.push_back(mk("div_neg",   2'b00, OP_DIV, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 5'b10000, 34));
    vecs.push_back(mk("div_min",   2'b00, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b10010, 34));
    vecs.push_back(mk("div_zero",  2'b00, OP_DIV, 32'd5,        32'd0,        32'hFFFFFFFF, 5'b10001, 1));
    vecs.push_back(mk("ldst",      2'b01, OP_ADD, 32'd5,        32'h1234,     32'h1234,     5'b00000, 1));
    vecs.push_back(mk("neg5",      2'b00, OP_NEG, 32'd5,        32'd0,        32'hFFFFFFFB, 5'b10000, 1));
    vecs.push_back(mk("op_f",      2'b00, 4'hF,   32'd5,        32'd7,        32'h0,        5'b01000, 1));
    vecs.push_back(mk("neg_min",   2'b00, OP_NEG, 32'h80000000, 32'd0,        32'h80000000, 5'b10010, 1));
    vecs.push_back(mk("and",       2'b00, OP_AND, 32'hF0F0,     32'hFF00,     32'hF000,     5'b00000, 1));
    vecs.push_back(mk("or",        2'b00, OP_OR,  32'hF0F0,     32'hFF00,     32'hFFF0,     5'b00000, 1));
    vecs.push_back(mk("xor",       2'b00, OP_XOR, 32'hF0F0,     32'hFF00,     32'h0FF0,     5'b00000, 1));
    vecs.push_back(mk("mov",       2'b00, OP_MOV, 32'd1,        32'hABCD0123, 32'hABCD0123, 5'b10000, 1));
    vecs.push_back(mk("add_wrap",  2'b00, OP_ADD, 32'hFFFFFFFF, 32'd1,        32'h0,        5'b01100, 1));
    vecs.push_back(mk("sub_brw",   2'b00, OP_SUB, 32'd3,        32'd5,        32'hFFFFFFFE, 5'b10000, 1));
    vecs.push_back(mk("sub_ovf",   2'b00, OP_SUB, 32'h80000000, 32'd1,        32'h7FFFFFFF, 5'b00110, 1));
    vecs.push_back(mk("mul_min",   2'b00, OP_MUL, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b10000, 34));
    vecs.push_back(mk("mul_big",   2'b00, OP_MUL, 32'd12345,    32'hFFFFFC18, 32'hFF43A158, 5'b10000, 34));
    vecs.push_back(mk("div_7_m2",  2'b00, OP_DIV, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 5'b10000, 34));
    vecs.push_back(mk("div_100_7", 2'b00, OP_DIV, 32'd100,      32'd7,        32'd14,       5'b00000, 34));
    vecs.push_back(mk("div_0_5",   2'b00, OP_DIV, 32'd0,        32'd5,        32'd0,        5'b01000, 34));
    vecs.push_back(mk("mul_0_m5",  2'b00, OP_MUL, 32'd0,        32'hFFFFFFFB, 32'd0,        5'b01000, 34));

    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 64'(result), 64'(0));
    check("rst_flags", 64'({negative, zero, carry, overflow, div_by_zero}), 64'(0));
    check("rst_busy_done", 64'({busy, done}), 64'(0));
    check("rst8_all", 64'({s8_result, s8_busy, s8_done, s8_n, s8_z, s8_c, s8_v, s8_dbz}), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i], 1'b0);

    // MUL with start pulses and operand changes while iterating
    run_vec(mk("mul_poke", 2'b00, OP_MUL, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 5'b10000, 34), 1'b1);
    // accepted in the same cycle done is high
    run_vec(mk("b2b_add", 2'b00, OP_ADD, 32'd2, 32'd3, 32'd5, 5'b00000, 1), 1'b0);

    held = result;
    @(posedge clk); #1;
    check("done_low_after", 64'(done), 64'(0));
    check("result_held", 64'(result), 64'(held));

    // reset during DIV RUN aborts without any done
    tc = 2'b00; op = OP_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_result", 64'(result), 64'(0));
    rst_n = 1'b1;
    saw = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) saw = 1;
    end
    check("abort_no_done", 64'(saw), 64'(0));
    run_vec(mk("post_rst_add", 2'b00, OP_ADD, 32'd2, 32'd3, 32'd5, 5'b00000, 1), 1'b0);

    run8("mul_12_11",  OP_MUL, 8'd12,  8'd11,  8'h84, 5'b10000);
    run8("div_100_7",  OP_DIV, 8'd100, 8'd7,   8'd14,  5'b00000);
    run8("div_min_m1", OP_DIV, 8'h80,  8'hFF,  8'h80,  5'b10010);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the processor datapath, replacing the purely combinational ALU. Single-cycle ops (add, sub, logic, negate, move, address pass-through) finish in one clock. MUL and DIV run iteratively over WIDTH cycles behind a start/busy/done handshake. Registered N/Z/C/V flags and a divide-by-zero flag feed the condition logic.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥ 4)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low; one clock, and reset is synchronous and active-low
- start  in  1  request; sampled only when busy=0
- type_code  in  2  00 = data processing, other = load/store (result = b)
- op_code  in  4  operation select, valid with start
- a  in  WIDTH  signed operand A
- b  in  WIDTH  signed operand B
- busy  out  1  high while a MUL/DIV is iterating
- done  out  1  one-cycle pulse: result/flags updated
- result  out  WIDTH  signed result, held until next done
- negative  out  1  result[WIDTH-1]
- zero  out  1  result == 0
- carry  out  1  ADD carry-out / SUB no-borrow; 0 otherwise
- overflow  out  1  signed overflow (ADD, SUB, NEG, DIV MIN/-1); 0 otherwise
- div_by_zero  out  1  DIV with b == 0

## Operation
- Opcodes (type_code 00): 0000 ADD, 0001 SUB (a−b), 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 NEG (−a), 1000 MOV (b), others → result 0.
- States: IDLE, RUN, FIN.
  - IDLE & start & single-cycle op → registers result/flags, done=1 next cycle, stays IDLE.
  - IDLE & start & MUL/DIV → latches |a|, |b|, result sign, clears counter; → RUN, busy=1.
  - RUN: one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle; after WIDTH steps → FIN.
  - FIN: applies sign correction, writes result/flags, pulses done, busy=0; → IDLE.
- MUL: low WIDTH bits of the signed product; carry=overflow=0.
- DIV: quotient truncated toward zero (−7/2 = −3); remainder not exposed.
  - b == 0: no RUN; result all-ones, div_by_zero=1, done next cycle.
  - MIN/−1: result = MIN, overflow=1.
- NEG of MIN: result = MIN, overflow=1.
- start while busy is ignored; operands are not re-sampled during RUN.
- negative and zero are derived from the registered result. div_by_zero is cleared on every other completion.

## Timing
- Reset (rst_n low at an edge): state IDLE; result, all flags, busy and done = 0. Aborts any RUN/FIN and produces no done.
- Single-cycle latency: start at edge E0 → result/flags/done valid after E0; done low after E1.
- MUL/DIV latency: start at E0; busy high after E0; WIDTH RUN edges; FIN edge E(WIDTH+1); done high and busy low after that edge. Total WIDTH+2 cycles until done.
- Back-to-back: a new start is accepted in the same cycle that done is high, provided busy=0.
- Outputs are held between done pulses.

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_MOV)
  - TYPE_DP = 2'b00
  - state encoding (IDLE, RUN, FIN)
- Natural sub-module: alu_seq_muldiv, the iterative magnitude datapath. It holds the accumulator/remainder, the shift registers and a $clog2(WIDTH)+1-bit counter, with a step/load/last interface. The top level owns the FSM, sign handling, the single-cycle ops and the flags.

## Test plan
- ADD 0x7FFFFFFF + 1 → result 0x80000000, N=1, V=1, C=0, done one cycle after start; SUB 5−5 → 0, Z=1, C=1.
- MUL −3 × 7 → −21 (0xFFFFFFEB), busy for 32 RUN cycles, done exactly 34 cycles after start; start pulses during busy are ignored.
- DIV −7/2 → −3; DIV 0x80000000/−1 → 0x80000000, V=1; DIV 5/0 → 0xFFFFFFFF, div_by_zero=1, done after 1 cycle.
- type_code=01, b=0x1234 → result 0x1234; NEG 5 → 0xFFFFFFFB, N=1; op 1111 → 0, Z=1.
- rst_n low mid-DIV (RUN cycle 10) → next cycle busy=0, done=0, result 0; no done follows; a new ADD 2+3 afterwards → 5.
- WIDTH=8 instance: MUL 12 × 11 → 0x84 (low byte), N=1; DIV 100/7 → 14; latency 10 cycles.
